// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Word-granular store buffer between the EX/MEM pipeline register and the data
// memory. Stores from the MEM stage go into a circular FIFO. The FIFO retires
// one entry to data memory per cycle whenever the memory port is free. A load
// in the MEM stage receives the data of the youngest buffered store to the
// same word. The pipeline stalls only when a store arrives and the buffer is
// full.
//
// Optional feature: define STORE_BUF_COALESCE_EN to enable store coalescing.
// With it, a store to the same word as the youngest entry overwrites that
// entry's data instead of allocating a new entry. The exception is when that
// entry is the head being drained this cycle.
//
// Parameters:
//   DEPTH      number of entries (power of two, >= 2)
//   DW         data width
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   st_valid   MEM-stage store request
//   st_addr    store byte address (bits [1:0] ignored)
//   st_data    store data
//   ld_valid   MEM-stage load
//   ld_addr    load byte address (bits [1:0] ignored)
//   ld_hit     a buffered store matches ld_addr (gated by ld_valid)
//   ld_data    forwarded data, 0 on miss
//   stall      freeze IF..MEM stages (store arriving while full)
//   mem_busy   data-memory port used by a load this cycle
//   mem_wr     write strobe to data memory
//   mem_addr   write address {entry_addr, 2'b00}, 0 when empty
//   mem_wdata  write data, 0 when empty
//   count      number of occupied entries
//   empty      count == 0
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [31:0]                st_addr,
    input  logic [DW-1:0]              st_data,
    input  logic                       ld_valid,
    input  logic [31:0]                ld_addr,
    output logic                       ld_hit,
    output logic [DW-1:0]              ld_data,
    output logic                       stall,
    input  logic                       mem_busy,
    output logic                       mem_wr,
    output logic [31:0]                mem_addr,
    output logic [DW-1:0]              mem_wdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Entry storage: word address plus data
    logic [29:0]   addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          full;
    logic          is_empty;
    logic          enq;
    logic          deq;
    logic          coal;
    logic [PW-1:0] youngest;
    logic          unused_addr_lsbs;

    // The byte-offset bits never take part in word matching.
    assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

    assign full     = (count_q == DEPTH_C);
    assign is_empty = (count_q == '0);
    assign youngest = tail_q - PW'(1);

    // Drain whenever something is buffered and the port is free. The signal
    // is held low while reset is asserted, so the reset edge never writes.
    assign mem_wr = !reset && !is_empty && !mem_busy;
    assign deq    = mem_wr;

`ifdef STORE_BUF_COALESCE_EN
    // Merge into the youngest entry, unless that entry is also the head
    // leaving this cycle (count==1 while draining). In that case allocate.
    assign coal = st_valid && !is_empty
               && (addr_q[youngest] == st_addr[31:2])
               && !(deq && (count_q == CW'(1)));
`else
    assign coal = 1'b0;
`endif

    // A store is not passed through, even when a drain frees a slot this
    // cycle. It is accepted on the first cycle the buffer is not full.
    assign enq   = st_valid && !full && !coal;
    assign stall = !reset && st_valid && full && !coal;

    assign mem_addr  = (reset || is_empty) ? 32'h0 : {addr_q[head_q], 2'b00};
    assign mem_wdata = (reset || is_empty) ? '0 : data_q[head_q];
    assign count     = count_q;
    assign empty     = is_empty;

    // Forwarding: walk the entries from oldest to youngest, so the last match
    // found is the youngest. The head entry being drained still counts.
    always_comb begin
        logic [PW-1:0] idx;
        ld_hit  = 1'b0;
        ld_data = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (!reset && ld_valid && (CW'(i) < count_q)
                && (addr_q[idx] == ld_addr[31:2])) begin
                ld_hit  = 1'b1;
                ld_data = data_q[idx];
            end
        end
    end

    // Next-state pointers. DEPTH is a power of two, so the pointers wrap on
    // their own.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (deq) head_d = head_q + PW'(1);
        if (enq) tail_d = tail_q + PW'(1);
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry storage has no reset. An entry's contents matter only while
    // the entry lies within head..head+count-1, and reset clears count.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= st_addr[31:2];
            data_q[tail_q] <= st_data;
        end else if (coal) begin
            data_q[youngest] <= st_data;
        end
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Word-granular store buffer between the EX/MEM pipeline register and the data memory. It accepts stores from the MEM stage and retires them to data memory one per cycle, whenever the memory port is free. Loads in the MEM stage are forwarded the youngest matching buffered store. The pipeline is stalled only when a store arrives while the buffer is full.

## Interface
Parameters:
- DEPTH, 4: number of entries; a power of two, at least 2.
- DW, 32: data width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- st_valid  in  1  MEM-stage store request (MemWr from EX/MEM).
- st_addr  in  32  store byte address; bits [1:0] ignored.
- st_data  in  DW  store data (Db from EX/MEM).
- ld_valid  in  1  MEM-stage load (MemToReg from EX/MEM).
- ld_addr  in  32  load byte address; bits [1:0] ignored.
- ld_hit  out  1  a buffered store matches ld_addr.
- ld_data  out  DW  forwarded data; 0 when ld_hit=0.
- stall  out  1  freeze the IF..MEM stages.
- mem_busy  in  1  data-memory port is in use by a load this cycle.
- mem_wr  out  1  write strobe to data memory.
- mem_addr  out  32  write address, {entry_addr, 2'b00}.
- mem_wdata  out  DW  write data.
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- empty  out  1  count==0.

## Operation
- Circular FIFO: head (oldest), tail (next free), count. Each entry holds {addr[31:2], data}. There are no per-entry valid bits; an entry is valid if it lies within head..head+count-1.
- Enqueue: st_valid && !full. The entry is written at tail, tail=tail+1 mod DEPTH.
- Drain:
  - mem_wr = !empty && !mem_busy, combinational.
  - mem_addr and mem_wdata always show the head entry (0 when empty).
  - On the edge with mem_wr=1, head advances.
- stall = st_valid && full, combinational. There is no pass-through, even if a drain occurs in the same cycle.
- A stalled store is re-presented by the frozen pipeline and is accepted on the first cycle with !full.
- Simultaneous enqueue and drain: count is unchanged; both pointers advance.
- Forwarding:
  - Combinational.
  - Compares ld_addr[31:2] against all valid entries, including the head entry being drained this cycle.
  - The youngest match wins.
  - A store presented in the same cycle is not visible to the load.
  - ld_hit is gated by ld_valid.
- On a load miss, the datapath uses data-memory output. This is safe because all older stores to that word are either in the buffer or already written.
- st_valid and ld_valid are never both high; if they are, the store is enqueued and the load searches pre-edge contents only.

## Timing
- Reset values:
  - head=tail=count=0, empty=1.
  - mem_wr=0, stall=0, ld_hit=0, ld_data=0, mem_addr=0, mem_wdata=0.
  - Reset mid-drain discards all entries; no write is issued on the reset edge.
- Store accepted at edge N is forwardable in cycle N+1 and earliest written to memory in cycle N+1.
- Drain throughput: one store per cycle while mem_busy=0.
- full when count==DEPTH. Pointers wrap at DEPTH.
- count saturates logically: no enqueue when full, no dequeue when empty.

## Configuration
- STORE_BUF_COALESCE_EN defined:
  - An accepted store whose addr[31:2] equals the youngest entry overwrites that entry's data instead of allocating.
  - This applies only if that entry is not the head being drained this cycle; in that case a new entry is allocated.
  - A coalescing store is accepted even when full (stall=0).
- Undefined: every store allocates a new entry; duplicates drain in order.

## Test plan
- Reset, then idle → empty=1, count=0, mem_wr=0, ld_hit=0 for 5 cycles.
- Store 0x10←0xAAAA_0001 with mem_busy=0 → count=1 next cycle; mem_wr=1 with mem_addr=0x10, mem_wdata=0xAAAA_0001; count=0 after that edge.
- mem_busy=1 held; stores to 0x0,0x4,0x8,0xC, then a store to 0x20 → stall=1 while count=4; release mem_busy → drains in order 0x0..0xC; 0x20 is accepted the cycle after the first drain; stall drops.
- Buffer 0x40←1 then 0x40←2 (coalescing off), mem_busy=1; load 0x40 → ld_hit=1, ld_data=2; load 0x44 → ld_hit=0, ld_data=0.
- Wrap: 10 back-to-back stores with mem_busy=0 → written data sequence matches issue order; count never exceeds 2.
- Coalescing on: store 0x40←1 then 0x40←2 with mem_busy=1 → count=1, single write of 2; reset asserted with count=3 → count=0, mem_wr=0 next cycle.
